// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg : shared widths, FSM state encoding and counter helper for the arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int CNT_W      = 10;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t LOAD      = 3'd1;
  localparam state_t START     = 3'd2;
  localparam state_t WAIT_BUSY = 3'd3;
  localparam state_t XFER      = 3'd4;
  localparam state_t DONE      = 3'd5;
  localparam state_t ERR       = 3'd6;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter_if : requester-side and master_device-side signal bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface i2c_master_arbiter_if
  import i2c_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]            req;
  logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]            req_rw;
  logic [I2C_DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]            grant;
  logic [N_REQ-1:0]            done;
  logic [N_REQ-1:0]            err;
  logic                        m_enable;
  logic [I2C_ADDR_W-1:0]       m_address;
  logic                        m_rw;
  logic [I2C_DATA_W-1:0]       m_data;
  logic                        m_ready;

  // Requesters plus master_device, seen from outside the arbiter
  modport master (
    output req, req_addr, req_rw, req_data, m_ready,
    input  grant, done, err, m_enable, m_address, m_rw, m_data
  );

  // The arbiter itself
  modport slave (
    input  req, req_addr, req_rw, req_data, m_ready,
    output grant, done, err, m_enable, m_address, m_rw, m_data
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first request at or after ptr_i
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N_REQ]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + i) % N_REQ);
      end
    end
    gnt_o[idx_o] = valid_o;
  end

endmodule

`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter : round-robin sharing of one I2C master_device among N_REQ requesters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int ENABLE_CYCLES = 5,
  parameter int START_TIMEOUT = 16,
  parameter int XFER_TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_master_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // START_TIMEOUT runs from the first START cycle, so WAIT_BUSY only gets what is left
  localparam logic [CNT_W-1:0] EN_LIM   = CNT_W'(ENABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'((START_TIMEOUT > ENABLE_CYCLES) ?
                                                 (START_TIMEOUT - ENABLE_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] XFER_LIM = CNT_W'(XFER_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    seen_low_q, seen_low_d;
  logic [I2C_ADDR_W-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [I2C_DATA_W-1:0]   data_q, data_d;

  logic [N_REQ-1:0]        arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arb_valid) state_d = LOAD;
      LOAD:      state_d = START;
      START: begin
        if (cnt_q >= EN_LIM) begin
          state_d = (seen_low_q || !bus.m_ready) ? XFER : WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!bus.m_ready)           state_d = XFER;
        else if (cnt_q >= WAIT_LIM) state_d = ERR;
      end
      XFER: begin
        if (bus.m_ready)            state_d = DONE;
        else if (cnt_q >= XFER_LIM) state_d = ERR;
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant    = '0;
    bus.done     = '0;
    bus.err      = '0;
    bus.m_enable = 1'b0;
    case (state_q)
      IDLE:  ;
      START: begin
        bus.grant    = gnt_q;
        bus.m_enable = 1'b1;
      end
      DONE: begin
        bus.grant = gnt_q;
        bus.done  = gnt_q;
      end
      ERR: begin
        bus.grant = gnt_q;
        bus.err   = gnt_q;
      end
      default: bus.grant = gnt_q;
    endcase
  end

  assign bus.m_address = addr_q;
  assign bus.m_rw      = rw_q;
  assign bus.m_data    = data_q;

  always_comb begin
    gnt_d  = gnt_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    addr_d = addr_q;
    rw_d   = rw_q;
    data_d = data_q;
    cnt_d  = (state_d != state_q) ? '0 : sat_inc(cnt_q);
    // Remember a busy indication seen during the enable pulse
    seen_low_d = (state_q == START) && (seen_low_q || !bus.m_ready);
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_gnt;
          idx_d = arb_idx;
        end
      end
      LOAD: begin
        addr_d = bus.req_addr[idx_q*I2C_ADDR_W +: I2C_ADDR_W];
        rw_d   = bus.req_rw[idx_q];
        data_d = bus.req_data[idx_q*I2C_DATA_W +: I2C_DATA_W];
      end
      DONE, ERR: ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      data_q     <= data_d;
    end
  end

endmodule

`default_nettype wire
